// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Bundle of display-driver signals. The master side owns the
//               result/control inputs (load, value, dp_in, blank, blink_en).
//               The slave side (the driver) owns the panel pins
//               (an, seg, dp, all active low).
// Revision    : 1.0 - initial release
// ============================================================================
//  Signals
//    load      capture value/dp_in/blank on this clock edge
//    value     four hex digits, digit 0 = value[3:0] (rightmost)
//    dp_in     decimal point request per digit, 1 = lit
//    blank     per-digit blank mask, 1 = digit dark
//    blink_en  whole-display blink enable
//    an        anode enables, active low, an[i] = digit i
//    seg       cathodes {g,f,e,d,c,b,a}, active low
//    dp        decimal point cathode, active low
// ============================================================================
interface seg7_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        blink_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output load, value, dp_in, blank, blink_en,
    input  an, seg, dp
  );

  modport slave (
    input  load, value, dp_in, blank, blink_en,
    output an, seg, dp
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Registered four-digit common-anode seven-segment driver.
//               It time-multiplexes a latched 16-bit value as hex digits and
//               supports per-digit blanking, decimal points and a
//               whole-display blink mode.
// Revision    : 1.0 - initial release
// ============================================================================
//  Parameters
//    REFRESH_DIV  clock cycles each digit stays lit (>= 1)
//    BLINK_DIV    clock cycles per blink half-period (>= 1)
//  Ports
//    clk     system clock, posedge
//    rst     synchronous active-high reset
//    bus_if  slave side of seg7_scan_driver_if (control in, panel pins out)
// ============================================================================
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  seg7_scan_driver_if.slave   bus_if
);

  // A counter needs at least one bit even when the divider is 1.
  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // --------------------------------------------------------------------------
  // Hex to active-low {g,f,e,d,c,b,a}
  // --------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [REF_W-1:0]   ref_cnt_q,   ref_cnt_d;
  logic [1:0]         idx_q,       idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [15:0]        val_q,   val_d;
  logic [3:0]         dp_q,    dp_d;
  logic [3:0]         blank_q, blank_d;

  logic [3:0]         an_q,     an_d;
  logic [6:0]         seg_q,    seg_d;
  logic               dp_out_q, dp_out_d;

  // Combinational helpers
  logic               ref_wrap;
  logic               blink_wrap;
  logic               dark;
  logic [3:0]         digit;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Scan timing: digit index steps once per refresh period.
    ref_wrap  = (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    idx_d     = ref_wrap ? idx_q + 2'd1 : idx_q;

    // Blink timing only runs while enabled. Dropping blink_en clears it, so
    // the next enable always starts with a full lit half-period.
    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (bus_if.blink_en) begin
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    // Shadow registers hold the displayed data between loads.
    val_d   = bus_if.load ? bus_if.value : val_q;
    dp_d    = bus_if.load ? bus_if.dp_in : dp_q;
    blank_d = bus_if.load ? bus_if.blank : blank_q;

    // The output stage is computed from the current state only. Any change
    // therefore reaches the pins one edge later, and all pins switch together.
    dark  = (bus_if.blink_en & blink_phase_q) | blank_q[idx_q];
    digit = val_q[{idx_q, 2'b00} +: 4];

    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    dp_out_d = 1'b1;
    if (!dark) begin
      an_d     = ~(4'b0001 << idx_q);
      seg_d    = hex_to_seg(digit);
      dp_out_d = ~dp_q[idx_q];
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q     <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      val_q         <= 16'h0000;
      dp_q          <= 4'h0;
      blank_q       <= 4'h0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_out_q      <= 1'b1;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      val_q         <= val_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
    end
  end

  assign bus_if.an  = an_q;
  assign bus_if.seg = seg_q;
  assign bus_if.dp  = dp_out_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver. Two instances run
//               side by side (REFRESH_DIV=4/BLINK_DIV=20 and REFRESH_DIV=1/
//               BLINK_DIV=1). A reference model predicts the pins from the
//               cycle count since reset and since blink enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int R1 = 4;
  localparam int B1 = 20;
  localparam int R2 = 1;
  localparam int B2 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if if1 ();
  seg7_scan_driver_if if2 ();

  seg7_scan_driver #(.REFRESH_DIV(R1), .BLINK_DIV(B1)) dut1 (
    .clk(clk), .rst(rst), .bus_if(if1.slave)
  );
  seg7_scan_driver #(.REFRESH_DIV(R2), .BLINK_DIV(B2)) dut2 (
    .clk(clk), .rst(rst), .bus_if(if2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [6:0]  hexseg [16];
  int          m_t   = 0;   // non-reset edges since the last reset
  int          m_bk  = 0;   // consecutive edges with blink_en=1
  logic [15:0] m_val   = '0;
  logic [3:0]  m_dp    = '0;
  logic [3:0]  m_blank = '0;

  // Pins {an, seg, dp} expected right after the coming edge.
  function automatic logic [11:0] model_out(input int rdiv, input int bdiv,
                                            input logic r, input logic bl);
    int         idx;
    logic       dark;
    logic [3:0] an_e;
    if (r) return {4'hF, 7'h7F, 1'b1};
    idx  = (m_t / rdiv) % 4;
    dark = (bl && (((m_bk / bdiv) % 2) == 1)) || m_blank[idx];
    if (dark) return {4'hF, 7'h7F, 1'b1};
    an_e      = 4'hF;
    an_e[idx] = 1'b0;
    return {an_e, hexseg[m_val[4*idx +: 4]], ~m_dp[idx]};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // One clock: drive inputs, predict, advance the model, sample and compare.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b, input logic bl);
    logic [11:0] e1, e2;
    rst          = r;
    if1.load     = ld;  if2.load     = ld;
    if1.value    = v;   if2.value    = v;
    if1.dp_in    = d;   if2.dp_in    = d;
    if1.blank    = b;   if2.blank    = b;
    if1.blink_en = bl;  if2.blink_en = bl;
    e1 = model_out(R1, B1, r, bl);
    e2 = model_out(R2, B2, r, bl);
    if (r) begin
      m_t = 0; m_bk = 0; m_val = '0; m_dp = '0; m_blank = '0;
    end else begin
      if (ld) begin
        m_val = v; m_dp = d; m_blank = b;
      end
      m_t++;
      m_bk = bl ? m_bk + 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("model_r4", {if1.an, if1.seg, if1.dp}, e1);
    chk("model_r1", {if2.an, if2.seg, if2.dp}, e2);
  endtask

  // --------------------------------------------------------------------------
  // Directed table: reset, load 16'h1A2F, one full scan at REFRESH_DIV=4
  // --------------------------------------------------------------------------
  typedef struct {
    logic        r;
    logic        ld;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
    logic        bl;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [15:0] rv;
    logic [3:0]  rd, rb;
    logic        rl, rr, rbl;

    hexseg[0]  = 7'b1000000; hexseg[1]  = 7'b1111001;
    hexseg[2]  = 7'b0100100; hexseg[3]  = 7'b0110000;
    hexseg[4]  = 7'b0011001; hexseg[5]  = 7'b0010010;
    hexseg[6]  = 7'b0000010; hexseg[7]  = 7'b1111000;
    hexseg[8]  = 7'b0000000; hexseg[9]  = 7'b0010000;
    hexseg[10] = 7'b0001000; hexseg[11] = 7'b0000011;
    hexseg[12] = 7'b1000110; hexseg[13] = 7'b0100001;
    hexseg[14] = 7'b0000110; hexseg[15] = 7'b0001110;

    vecs[0] = '{1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'b1111, 7'b1111111, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 16'h1A2F, 4'h0, 4'h0, 1'b0, 4'b1110, 7'b1000000, 1'b1};
    for (int i = 2; i < 18; i++) begin
      vecs[i] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'b1110, 7'b0001110, 1'b1};
      if (i >= 5  && i <= 8)  begin vecs[i].an = 4'b1101; vecs[i].seg = 7'b0100100; end
      if (i >= 9  && i <= 12) begin vecs[i].an = 4'b1011; vecs[i].seg = 7'b0001000; end
      if (i >= 13 && i <= 16) begin vecs[i].an = 4'b0111; vecs[i].seg = 7'b1111001; end
    end

    rst = 1'b1;
    if1.load = 0; if1.value = '0; if1.dp_in = '0; if1.blank = '0; if1.blink_en = 0;
    if2.load = 0; if2.value = '0; if2.dp_in = '0; if2.blank = '0; if2.blink_en = 0;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].ld, vecs[i].v, vecs[i].d, vecs[i].b, vecs[i].bl);
      chk($sformatf("scan_vec%0d", i), {if1.an, if1.seg, if1.dp},
          {vecs[i].an, vecs[i].seg, vecs[i].dp});
    end

    // Decode sweep: every digit shows the same nibble; all four slots visited.
    for (int h = 0; h < 16; h++) begin
      rv = {4{h[3:0]}};
      step(1'b0, 1'b1, rv, 4'h0, 4'h0, 1'b0);
      for (int c = 0; c < 4 * R1; c++) begin
        step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
        chk($sformatf("decode_%0h", h), {4'h0, if1.seg, if1.dp}, {4'h0, hexseg[h], 1'b1});
      end
    end

    // Decimal points on digits 0 and 2, digit 3 blanked.
    step(1'b0, 1'b1, 16'h8888, 4'b0101, 4'b1000, 1'b0);
    for (int c = 0; c < 8 * R1; c++)
      step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);

    // Value changes without load are ignored; a load shows one edge later.
    step(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 6; c++)
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    chk("no_load_hold", {4'h0, if1.seg, 1'b0}, {4'h0, 7'b1000000, 1'b0});
    step(1'b0, 1'b1, 16'h5555, 4'h0, 4'h0, 1'b0);
    chk("load_edge_old", {4'h0, if1.seg, 1'b0}, {4'h0, 7'b1000000, 1'b0});
    step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    chk("load_next_new", {4'h0, if1.seg, 1'b0}, {4'h0, 7'b0010010, 1'b0});

    // Blink: 20 lit, 20 dark, then drop blink_en inside the dark window.
    for (int c = 0; c < B1; c++) begin
      step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
      chk("blink_lit", {if1.an == 4'hF, 11'h0}, 12'h0);
    end
    for (int c = 0; c < B1; c++) begin
      step(1'b0, c == 7, 16'h9999, 4'h0, 4'h0, 1'b1);  // load must not disturb blink
      chk("blink_dark", {if1.an, 8'h0}, {4'hF, 8'h0});
    end
    for (int c = 0; c < B1; c++)
      step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
    for (int c = 0; c < 5; c++)
      step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    chk("blink_off_lit", {if1.an == 4'hF, 11'h0}, 12'h0);

    // Reset in a dark window with load and blink_en high: reset wins.
    for (int c = 0; c < B1 + 3; c++)
      step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 16'h7777, 4'hF, 4'h0, 1'b1);
    chk("rst_mid_blink", {if1.an, if1.seg, if1.dp}, {4'hF, 7'h7F, 1'b1});
    step(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
    chk("post_rst_first", {if1.an, if1.seg, if1.dp}, {4'b1110, 7'b1000000, 1'b1});

    // Randomized traffic checked against the model on both instances.
    rbl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rl  = ($urandom_range(0, 3) == 0);
      rv  = 16'($urandom);
      rd  = 4'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 59) == 0) rbl = ~rbl;
      step(rr, rl, rv, rd, rb, rbl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
